// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// It covers three cases:
//   - the load-use interlock;
//   - EX-resolved control redirects;
//   - a variable-latency data-memory handshake, guarded by a watchdog.
// It also keeps saturating counters of stall cycles and redirect flushes.
//
// Ports:
//   clk, rstn                     clock, asynchronous active-low reset
//   id_rs1/id_rs2, id_use_rs1/2   sources of the ID instruction and their use flags
//   ex_rd, ex_memread             destination and load flag of the EX instruction
//   ex_redirect                   EX resolved a taken branch/jump
//   mem_req, mem_ack              data-memory access handshake
//   cnt_clear                     synchronous clear of both counters
//   pc_write .. exmem_write       pipeline register update enables
//   ifid_flush, idex_flush        bubble insertion into IF/ID and ID/EX
//   memwb_bubble                  bubble insertion into MEM/WB
//   pc_redirect                   select the EX target as next PC
//   mem_abort, mem_timeout        watchdog abort pulse / sticky error flag
//   stall_cycles, flush_count     performance counters
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             cnt_clear,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic             pc_redirect,
  output logic             mem_abort,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]   flush_count_q, flush_count_d;

  logic pending;
  logic at_limit;
  logic freeze;
  logic abort;
  logic load_use;
  logic lu_stall;

  always_comb begin
    pending  = mem_req & ~mem_ack;
    at_limit = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT));
    freeze   = pending & ((state_q == RUN) | ~at_limit);
    // Abort only happens in MEM_WAIT, once the limit is reached.
    abort    = pending & (state_q == MEM_WAIT) & at_limit;
    load_use = ex_memread & (ex_rd != 5'd0) &
               ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    lu_stall = ~freeze & ~ex_redirect & load_use;
  end

  // Control outputs are decided by strict priority:
  // reset, then freeze, then redirect, then load-use.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    pc_redirect  = 1'b0;
    mem_abort    = 1'b0;
    if (!rstn) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
    end else begin
      mem_abort = abort;
      if (freeze) begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_write  = 1'b0;
        memwb_bubble = 1'b1;
      end else if (ex_redirect) begin
        pc_redirect = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
      end else if (load_use) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else begin
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        // A dropped mem_req counts as completion.
        if (!pending) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (freeze) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
          state_d       = RUN;
          wait_cnt_d    = '0;
          mem_timeout_d = 1'b1;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (cnt_clear) begin
      stall_cycles_d = '0;
      flush_count_d  = '0;
    end else begin
      if ((freeze | lu_stall) && (stall_cycles_q != '1))
        stall_cycles_d = stall_cycles_q + CNT_W'(1);
      if (pc_redirect && (flush_count_q != '1))
        flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl.
// Stimulus pushes hand-computed expectations per cycle into a queue, and a
// negedge monitor pops and compares them against the DUT.
// Configuration: MEM_TIMEOUT=4, CNT_W=4.
module tb_hazard_ctrl;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 4;

  // Control vector: {pcw, ifw, idw, exw, iff, idf, bub, red, abort}
  localparam logic [8:0] C_DEF = 9'b111100000;
  localparam logic [8:0] C_FRZ = 9'b000000100;
  localparam logic [8:0] C_RED = 9'b111111010;
  localparam logic [8:0] C_LU  = 9'b001101000;
  localparam logic [8:0] C_RST = 9'b000011100;
  localparam logic [8:0] C_ABT = 9'b111100001;

  typedef struct packed {
    logic [8:0]    ctl;
    logic          to;
    logic [CW-1:0] st;
    logic [CW-1:0] fl;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_memread, ex_redirect, mem_req, mem_ack, cnt_clear;
  logic pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush;
  logic memwb_bubble, pc_redirect, mem_abort, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_count;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ack(mem_ack), .cnt_clear(cnt_clear),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_bubble(memwb_bubble), .pc_redirect(pc_redirect), .mem_abort(mem_abort),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // Monitor: compares one expectation per cycle on the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [8:0] act;
      e   = q.pop_front();
      act = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush,
             memwb_bubble, pc_redirect, mem_abort};
      checks++;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL ctl @%0t: got %b expected %b", $time, act, e.ctl);
      end
      checks++;
      if (mem_timeout !== e.to) begin
        errors++;
        $display("FAIL mem_timeout @%0t: got %b expected %b", $time, mem_timeout, e.to);
      end
      checks++;
      if (stall_cycles !== e.st || flush_count !== e.fl) begin
        errors++;
        $display("FAIL counters @%0t: got st=%0d fl=%0d expected st=%0d fl=%0d",
                 $time, stall_cycles, flush_count, e.st, e.fl);
      end
    end
  end

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_memread = 1'b0; ex_redirect = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0; cnt_clear = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
    ex_memread = 1'b1; ex_rd = rd;
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
  endtask

  task automatic set_mem(input logic req, input logic ack);
    mem_req = req; mem_ack = ack;
  endtask

  // Queue the expectation for the current cycle, then advance one cycle.
  task automatic step(input logic [8:0] ctl, input logic to, input int st, input int fl);
    exp_t e;
    e.ctl = ctl; e.to = to; e.st = CW'(st); e.fl = CW'(fl);
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    @(posedge clk); #1;
    step(C_RST, 1'b0, 0, 0);
    rstn = 1'b1;
    step(C_DEF, 1'b0, 0, 0);

    // Load-use on rs2.
    set_lu(5'd5, 5'd1, 1'b1, 5'd5, 1'b1);
    step(C_LU, 1'b0, 0, 0);
    // x0 destination never stalls.
    set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    step(C_DEF, 1'b0, 1, 0);
    // Matching rs1 that is not actually read.
    set_lu(5'd7, 5'd7, 1'b0, 5'd3, 1'b1);
    step(C_DEF, 1'b0, 1, 0);
    // Redirect beats load-use.
    set_lu(5'd5, 5'd1, 1'b0, 5'd5, 1'b1);
    ex_redirect = 1'b1;
    step(C_RED, 1'b0, 1, 0);
    idle();
    step(C_DEF, 1'b0, 1, 1);

    // Memory wait, ack in the 4th cycle.
    set_mem(1'b1, 1'b0);
    step(C_FRZ, 1'b0, 1, 1);
    step(C_FRZ, 1'b0, 2, 1);
    step(C_FRZ, 1'b0, 3, 1);
    set_mem(1'b1, 1'b1);
    step(C_DEF, 1'b0, 4, 1);
    // Same-cycle ack: zero stall.
    step(C_DEF, 1'b0, 4, 1);

    // Freeze masks redirect over a 2-cycle wait.
    ex_redirect = 1'b1;
    set_mem(1'b1, 1'b0);
    step(C_FRZ, 1'b0, 4, 1);
    step(C_FRZ, 1'b0, 5, 1);
    set_mem(1'b1, 1'b1);
    step(C_RED, 1'b0, 6, 1);
    idle();
    step(C_DEF, 1'b0, 6, 2);

    // Watchdog: never acked.
    set_mem(1'b1, 1'b0);
    step(C_FRZ, 1'b0, 6, 2);
    step(C_FRZ, 1'b0, 7, 2);
    step(C_FRZ, 1'b0, 8, 2);
    step(C_FRZ, 1'b0, 9, 2);
    step(C_ABT, 1'b0, 10, 2);
    step(C_FRZ, 1'b1, 10, 2);
    // Dropped mem_req releases the wait.
    set_mem(1'b0, 1'b0);
    step(C_DEF, 1'b1, 11, 2);

    // Reset in the middle of a wait.
    set_mem(1'b1, 1'b0);
    step(C_FRZ, 1'b1, 11, 2);
    rstn = 1'b0;
    step(C_RST, 1'b0, 0, 0);
    step(C_RST, 1'b0, 0, 0);
    rstn = 1'b1;
    set_mem(1'b0, 1'b0);
    step(C_DEF, 1'b0, 0, 0);

    // Stall counter saturation, then clear.
    set_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 20; i++)
      step(C_LU, 1'b0, (i > 15) ? 15 : i, 0);
    cnt_clear = 1'b1;
    step(C_LU, 1'b0, 15, 0);
    idle();
    step(C_DEF, 1'b0, 0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int n = 0; n < 10 && q.size() > 0; n++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
